dispatch_queue: RTL and testbench

//  Buffered, parametrised dispatcher between instruction decode and NUM_UNITS reservation stations.

---
 rtl/dispatch_queue.sv | 131 +++++++++++++
 tb/tb_dispatch_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_queue.sv
// In-order dispatch FIFO between decode and NUM_UNITS reservation stations.
// Issues the head to its target unit and reports the taken RS tag one cycle later.
module dispatch_queue #(
  parameter int unsigned NUM_UNITS    = 8,
  parameter int unsigned RS_ID_WIDTH  = 5,
  parameter int unsigned DECODE_WIDTH = 64,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STALL_WIDTH  = 16,
  localparam int unsigned UnitW       = $clog2(NUM_UNITS) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [UnitW-1:0]                 in_unit,
  input  logic [4:0]                       in_flags,
  input  logic [DECODE_WIDTH-1:0]          in_decode,
  output logic [NUM_UNITS-1:0]             unit_valid,
  input  logic [NUM_UNITS-1:0]             unit_ready,
  input  logic [NUM_UNITS*RS_ID_WIDTH-1:0] unit_id,
  output logic [DECODE_WIDTH-1:0]          unit_decode,
  output logic                             disp_valid,
  output logic [RS_ID_WIDTH-1:0]           disp_id,
  output logic [4:0]                       disp_flags,
  output logic                             illegal,
  output logic [STALL_WIDTH-1:0]           stall_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [UnitW-1:0]        unit_mem   [DEPTH];
  logic [4:0]              flags_mem  [DEPTH];
  logic [DECODE_WIDTH-1:0] decode_mem [DEPTH];

  logic [PtrW-1:0]        rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]        count_q;
  logic                   disp_valid_q, illegal_q;
  logic [RS_ID_WIDTH-1:0] disp_id_q;
  logic [4:0]             disp_flags_q;
  logic [STALL_WIDTH-1:0] stall_q;

  logic                   empty, full, head_legal, ready_hit;
  logic                   push, pop, handshake, stall;
  logic [UnitW-1:0]       head_unit;
  logic [NUM_UNITS-1:0]   head_sel;
  logic [RS_ID_WIDTH-1:0] sel_id;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CntW'(DEPTH));
  assign in_ready   = !full;
  assign head_unit  = unit_mem[rd_ptr_q];
  assign head_legal = (head_unit < UnitW'(NUM_UNITS));

  // Decode head target into a one-hot select and pick that unit's free RS tag.
  always_comb begin
    head_sel = '0;
    sel_id   = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (head_unit == UnitW'(u)) begin
        head_sel[u] = 1'b1;
        sel_id      = unit_id[u*RS_ID_WIDTH +: RS_ID_WIDTH];
      end
    end
  end

  assign unit_valid  = (empty || flush) ? '0 : head_sel;
  assign unit_decode = decode_mem[rd_ptr_q];
  assign ready_hit   = |(head_sel & unit_ready);
  assign handshake   = |(unit_valid & unit_ready);
  // Illegal heads are dropped without waiting on any unit.
  assign pop         = handshake | (!empty & !flush & !head_legal);
  assign push        = in_valid & in_ready & !flush;
  assign stall       = !empty & head_legal & !flush & !ready_hit;

  always_ff @(posedge clk) begin
    if (push) begin
      unit_mem[wr_ptr_q]   <= in_unit;
      flags_mem[wr_ptr_q]  <= in_flags;
      decode_mem[wr_ptr_q] <= in_decode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_valid_q <= 1'b0;
      disp_id_q    <= '0;
      disp_flags_q <= '0;
      illegal_q    <= 1'b0;
      stall_q      <= '0;
    end else begin
      disp_valid_q <= handshake;
      illegal_q    <= !empty & !flush & !head_legal;
      if (handshake) begin
        disp_id_q    <= sel_id;
        disp_flags_q <= flags_mem[rd_ptr_q];
      end
      if (stall && (stall_q != '1)) begin
        stall_q <= stall_q + STALL_WIDTH'(1);
      end
    end
  end

  assign disp_valid  = disp_valid_q;
  assign disp_id     = disp_id_q;
  assign disp_flags  = disp_flags_q;
  assign illegal     = illegal_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// Randomised scoreboard bench for dispatch_queue against a queue-based reference model.
module tb_dispatch_queue;
  localparam int NU = 8;
  localparam int RW = 5;
  localparam int DW = 64;
  localparam int DP = 4;
  localparam int SW = 16;
  localparam int UW = $clog2(NU) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [UW-1:0]     in_unit = '0;
  logic [4:0]        in_flags = '0;
  logic [DW-1:0]     in_decode = '0;
  logic [NU-1:0]     unit_valid;
  logic [NU-1:0]     unit_ready = '0;
  logic [NU*RW-1:0]  unit_id = '0;
  logic [DW-1:0]     unit_decode;
  logic              disp_valid;
  logic [RW-1:0]     disp_id;
  logic [4:0]        disp_flags;
  logic              illegal;
  logic [SW-1:0]     stall_count;

  dispatch_queue #(
    .NUM_UNITS(NU), .RS_ID_WIDTH(RW), .DECODE_WIDTH(DW), .DEPTH(DP), .STALL_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_unit(in_unit), .in_flags(in_flags), .in_decode(in_decode),
    .unit_valid(unit_valid), .unit_ready(unit_ready), .unit_id(unit_id),
    .unit_decode(unit_decode), .disp_valid(disp_valid), .disp_id(disp_id),
    .disp_flags(disp_flags), .illegal(illegal), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [UW-1:0] unit;
    logic [4:0]    flags;
    logic [DW-1:0] dec;
  } entry_t;

  typedef struct {
    bit            is_illegal;
    logic [RW-1:0] id;
    logic [4:0]    flags;
  } event_t;

  entry_t        mq[$];
  event_t        expq[$];
  int            m_stall = 0;
  logic [RW-1:0] m_id = '0;
  logic [4:0]    m_flags = '0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: checks combinational outputs, then predicts the next edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      begin
        logic [NU-1:0] exp_uv;
        event_t        ev;
        bit            do_pop;
        bit            do_push;
        int            u;
        chk("in_ready", 64'(in_ready), 64'(mq.size() < DP));
        exp_uv = '0;
        if (mq.size() > 0 && !flush && mq[0].unit < NU) exp_uv[mq[0].unit] = 1'b1;
        chk("unit_valid", 64'(unit_valid), 64'(exp_uv));
        if (mq.size() > 0) chk("unit_decode", unit_decode, mq[0].dec);
        if (rst) begin
          mq.delete();
          m_stall = 0;
          m_id    = '0;
          m_flags = '0;
        end else if (flush) begin
          mq.delete();
        end else begin
          do_pop  = 1'b0;
          do_push = in_valid && (mq.size() < DP);
          if (mq.size() > 0) begin
            u = int'(mq[0].unit);
            if (u >= NU) begin
              ev.is_illegal = 1'b1;
              ev.id         = m_id;
              ev.flags      = m_flags;
              expq.push_back(ev);
              do_pop = 1'b1;
            end else if (unit_ready[u]) begin
              ev.is_illegal = 1'b0;
              ev.id         = unit_id[u*RW +: RW];
              ev.flags      = mq[0].flags;
              m_id          = ev.id;
              m_flags       = ev.flags;
              expq.push_back(ev);
              do_pop = 1'b1;
            end else if (m_stall < (1 << SW) - 1) begin
              m_stall++;
            end
          end
          if (do_pop) void'(mq.pop_front());
          if (do_push) begin
            entry_t e;
            e.unit  = in_unit;
            e.flags = in_flags;
            e.dec   = in_decode;
            mq.push_back(e);
          end
        end
      end
    end
  end

  // Monitor: registered outputs after each edge against popped expectations.
  initial begin
    @(posedge clk);
    forever begin
      @(posedge clk);
      #2;
      chk("stall_count", 64'(stall_count), 64'(m_stall));
      chk("disp_id_hold", 64'(disp_id), 64'(m_id));
      chk("disp_flags_hold", 64'(disp_flags), 64'(m_flags));
      if (disp_valid || illegal) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: disp_valid=%b illegal=%b, none expected at %0t",
                   disp_valid, illegal, $time);
        end else begin
          event_t ev;
          ev = expq.pop_front();
          chk("event_kind", 64'({disp_valid, illegal}), ev.is_illegal ? 64'd1 : 64'd2);
          if (!ev.is_illegal) begin
            chk("disp_id", 64'(disp_id), 64'(ev.id));
            chk("disp_flags", 64'(disp_flags), 64'(ev.flags));
          end
        end
      end else if (expq.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL missing_event: got no pulse, expected %0d pending at %0t",
                 expq.size(), $time);
        expq.delete();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int unit, input int fl);
    in_valid  = 1'b1;
    in_unit   = UW'(unit);
    in_flags  = 5'(fl);
    in_decode = {$urandom, $urandom};
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [NU*RW-1:0] ids;
    repeat (3) step();
    rst = 1'b0;

    // Single issue to unit 2 with tag 7.
    unit_ready = '1;
    ids = {$urandom, $urandom};
    ids[2*RW +: RW] = 5'd7;
    unit_id = ids;
    push(2, 5'b10001);
    step();
    idle();
    repeat (4) step();

    // Fill while stalled, then release back-to-back.
    unit_ready = '0;
    for (int i = 0; i < 5; i++) begin
      push(int'($urandom_range(0, NU - 1)), int'($urandom_range(0, 31)));
      step();
    end
    idle();
    repeat (3) step();
    unit_ready = '1;
    repeat (6) step();

    // Illegal unit followed by a legal one.
    push(9, 5'b01010);
    step();
    push(1, 5'b00111);
    step();
    idle();
    repeat (4) step();

    // Flush a queue of three with a concurrent push.
    unit_ready = '0;
    for (int i = 0; i < 3; i++) begin
      push(int'($urandom_range(0, NU - 1)), int'($urandom_range(0, 31)));
      step();
    end
    flush = 1'b1;
    push(3, 5'b11111);
    step();
    flush = 1'b0;
    idle();
    unit_ready = '1;
    repeat (3) step();

    // Full queue, then streaming push/pop across pointer wrap.
    unit_ready = '0;
    for (int i = 0; i < DP; i++) begin
      push(int'($urandom_range(0, NU - 1)), int'($urandom_range(0, 31)));
      step();
    end
    unit_ready = '1;
    for (int i = 0; i < 10; i++) begin
      push(int'($urandom_range(0, NU - 1)), int'($urandom_range(0, 31)));
      unit_id = {$urandom, $urandom};
      step();
    end
    idle();
    repeat (6) step();

    // Reset with two queued entries and a nonzero stall count.
    unit_ready = '0;
    for (int i = 0; i < 2; i++) begin
      push(int'($urandom_range(0, NU - 1)), int'($urandom_range(0, 31)));
      step();
    end
    idle();
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (2) step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_unit    = ($urandom_range(0, 9) == 0) ? UW'($urandom_range(NU, (1 << UW) - 1))
                                               : UW'($urandom_range(0, NU - 1));
      in_flags   = 5'($urandom);
      in_decode  = {$urandom, $urandom};
      unit_ready = NU'($urandom);
      unit_id    = {$urandom, $urandom};
      flush      = ($urandom_range(0, 49) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      step();
    end

    rst        = 1'b0;
    flush      = 1'b0;
    idle();
    unit_ready = '1;
    repeat (12) step();
    #3;
    chk("drained_events", 64'(expq.size()), 64'd0);
    chk("drained_queue", 64'(mq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
